// File: rtl/ram_xfer_pkg.sv
// rtl/ram_xfer_pkg.sv - Opcodes, state encoding and default widths for ram_xfer_ctrl
package ram_xfer_pkg;

    localparam int RAM_AW = 8;
    localparam int RAM_DW = 8;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;
    localparam logic [1:0] OP_COPY = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_RSP,
        ST_WR,
        ST_FILL,
        ST_CP_RD,
        ST_CP_WR,
        ST_DONE
    } xfer_state_t;

endpackage

// File: rtl/ram_xfer_ctrl.sv
// rtl/ram_xfer_ctrl.sv - Command sequencer driving the data RAM (RD/WR/FILL/COPY)
// Optional running write checksum enabled by RAM_XFER_CHKSUM_EN.
module ram_xfer_ctrl
    import ram_xfer_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          done,
    output logic          busy,
    output logic          rd_ram,
    output logic          wr_ram,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] data_in_ram,
    input  logic [DW-1:0] data_out_ram,
    output logic [DW-1:0] chksum
);

    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;

    xfer_state_t   state, nxt_state;
    logic [AW:0]   cnt, nxt_cnt;
    logic [AW-1:0] src_a, nxt_src;
    logic [AW-1:0] dst_a, nxt_dst;
    logic [DW-1:0] data_r, nxt_data;
    logic          nxt_rd, nxt_wr, nxt_rsp_valid, nxt_done;
    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_din;
    logic [AW:0]   len_full;

    // RD_RSP and DONE are the completion cycles; they already accept the next command.
    assign cmd_ready = (state == ST_IDLE) || (state == ST_RD_RSP) || (state == ST_DONE);
    assign busy      = ~cmd_ready;

    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_src       = src_a;
        nxt_dst       = dst_a;
        nxt_data      = data_r;
        nxt_rd        = 1'b0;
        nxt_wr        = 1'b0;
        nxt_addr      = '0;
        nxt_din       = '0;
        nxt_rsp_valid = 1'b0;
        nxt_done      = 1'b0;
        len_full      = {1'b0, cmd_len};
        if (cmd_len == '0) len_full = {1'b1, {AW{1'b0}}};

        case (state)
            ST_IDLE, ST_RD_RSP, ST_DONE: begin
                nxt_state = ST_IDLE;
                if (cmd_valid) begin
                    nxt_data = cmd_data;
                    case (cmd_op)
                        OP_RD: begin
                            nxt_state = ST_RD;
                            nxt_rd    = 1'b1;
                            nxt_addr  = cmd_src;
                        end
                        OP_WR: begin
                            nxt_state = ST_WR;
                            nxt_wr    = 1'b1;
                            nxt_addr  = cmd_dst;
                            nxt_din   = cmd_data;
                        end
                        OP_FILL: begin
                            nxt_state = ST_FILL;
                            nxt_wr    = 1'b1;
                            nxt_addr  = cmd_dst;
                            nxt_din   = cmd_data;
                            nxt_dst   = cmd_dst + ADDR_ONE;
                            nxt_cnt   = len_full - CNT_ONE;
                        end
                        default: begin
                            nxt_state = ST_CP_RD;
                            nxt_rd    = 1'b1;
                            nxt_addr  = cmd_src;
                            nxt_src   = cmd_src + ADDR_ONE;
                            nxt_dst   = cmd_dst;
                            nxt_cnt   = len_full;
                        end
                    endcase
                end
            end
            ST_RD: begin
                nxt_state     = ST_RD_RSP;
                nxt_rsp_valid = 1'b1;
                nxt_done      = 1'b1;
            end
            ST_WR: begin
                nxt_state = ST_DONE;
                nxt_done  = 1'b1;
            end
            ST_FILL: begin
                if (cnt == '0) begin
                    nxt_state = ST_DONE;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_wr   = 1'b1;
                    nxt_addr = dst_a;
                    nxt_din  = data_r;
                    nxt_dst  = dst_a + ADDR_ONE;
                    nxt_cnt  = cnt - CNT_ONE;
                end
            end
            ST_CP_RD: begin
                // The registered write-data output doubles as the copy hold register.
                nxt_state = ST_CP_WR;
                nxt_wr    = 1'b1;
                nxt_addr  = dst_a;
                nxt_din   = data_out_ram;
                nxt_dst   = dst_a + ADDR_ONE;
                nxt_cnt   = cnt - CNT_ONE;
            end
            default: begin
                if (cnt == '0) begin
                    nxt_state = ST_DONE;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_state = ST_CP_RD;
                    nxt_rd    = 1'b1;
                    nxt_addr  = src_a;
                    nxt_src   = src_a + ADDR_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            src_a       <= '0;
            dst_a       <= '0;
            data_r      <= '0;
            rd_ram      <= 1'b0;
            wr_ram      <= 1'b0;
            ram_addr    <= '0;
            data_in_ram <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            done        <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            src_a       <= nxt_src;
            dst_a       <= nxt_dst;
            data_r      <= nxt_data;
            rd_ram      <= nxt_rd;
            wr_ram      <= nxt_wr;
            ram_addr    <= nxt_addr;
            data_in_ram <= nxt_din;
            rsp_valid   <= nxt_rsp_valid;
            done        <= nxt_done;
            if (state == ST_RD) rsp_data <= data_out_ram;
        end
    end

`ifdef RAM_XFER_CHKSUM_EN
    always_ff @(posedge clock) begin
        if (reset)       chksum <= '0;
        else if (wr_ram) chksum <= chksum ^ data_in_ram;
    end
`else
    assign chksum = '0;
`endif

endmodule
